ins_decode_stage: RTL and testbench

INS_DECODE_STAGE -- requirements
Module: ins_decode_stage

---
 rtl/ins_pkg.sv | 27 ++
 rtl/ins_decode_stage_if.sv | 33 +++
 rtl/ins_field_split.sv | 42 ++++
 rtl/ins_decode_stage.sv | 133 +++++++++++++
 tb/tb_ins_decode_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ins_pkg.sv
// Shared decode-stage definitions: instruction field offsets, word width and occupancy states.
package ins_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Instruction layout, MSB to LSB: {opcode, rt_rd, rs, imm}
  function automatic int ins_width(input int opw, input int regw, input int immw);
    return opw + 2 * regw + immw;
  endfunction

  function automatic int rs_lsb(input int immw);
    return immw;
  endfunction

  function automatic int rt_rd_lsb(input int regw, input int immw);
    return immw + regw;
  endfunction

  function automatic int op_lsb(input int regw, input int immw);
    return immw + 2 * regw;
  endfunction

endpackage

// File: rtl/ins_decode_stage_if.sv
// Instruction-in / decoded-bundle-out handshake bundle for the decode stage.
interface ins_decode_stage_if
  import ins_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int REGW  = 1,
  parameter int IMMW  = 3,
  parameter int DATAW = 8
);
  localparam int INSW = ins_width(OPW, REGW, IMMW);

  logic             in_valid;
  logic             in_ready;
  logic [INSW-1:0]  instruct;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   opcode;
  logic [REGW-1:0]  rt_rd;
  logic [REGW-1:0]  rs;
  logic [DATAW-1:0] imm_ext;
  logic             illegal;

  modport slave (
    input  in_valid, instruct, out_ready,
    output in_ready, out_valid, opcode, rt_rd, rs, imm_ext, illegal
  );

  modport master (
    output in_valid, instruct, out_ready,
    input  in_ready, out_valid, opcode, rt_rd, rs, imm_ext, illegal
  );

endinterface

// File: rtl/ins_field_split.sv
// Combinational instruction decode: field split, immediate extension, illegal-opcode lookup.
module ins_field_split
  import ins_pkg::*;
#(
  parameter int                  OPW          = 3,
  parameter int                  REGW         = 1,
  parameter int                  IMMW         = 3,
  parameter int                  DATAW        = 8,
  parameter int                  SEXT         = 1,
  parameter logic [2**OPW-1:0]   ILLEGAL_MASK = '0
) (
  input  logic [ins_width(OPW, REGW, IMMW)-1:0] instruct_i,
  output logic [OPW-1:0]                        opcode_o,
  output logic [REGW-1:0]                       rt_rd_o,
  output logic [REGW-1:0]                       rs_o,
  output logic [DATAW-1:0]                      imm_ext_o,
  output logic                                  illegal_o
);

  localparam int OP_LSB = op_lsb(REGW, IMMW);
  localparam int RT_LSB = rt_rd_lsb(REGW, IMMW);
  localparam int RS_LSB = rs_lsb(IMMW);

  logic [IMMW-1:0] imm;

  assign opcode_o  = instruct_i[OP_LSB +: OPW];
  assign rt_rd_o   = instruct_i[RT_LSB +: REGW];
  assign rs_o      = instruct_i[RS_LSB +: REGW];
  assign imm       = instruct_i[IMMW-1:0];
  assign illegal_o = ILLEGAL_MASK[opcode_o];

  generate
    if (DATAW == IMMW) begin : g_ext_none
      assign imm_ext_o = imm;
    end else begin : g_ext
      logic fill;
      assign fill      = (SEXT != 0) ? imm[IMMW-1] : 1'b0;
      assign imm_ext_o = {{(DATAW-IMMW){fill}}, imm};
    end
  endgenerate

endmodule

// File: rtl/ins_decode_stage.sv
// Decode stage: one-cycle latency, main + skid register for full throughput with a registered in_ready.
module ins_decode_stage
  import ins_pkg::*;
#(
  parameter int                OPW          = 3,
  parameter int                REGW         = 1,
  parameter int                IMMW         = 3,
  parameter int                DATAW        = 8,
  parameter int                SEXT         = 1,
  parameter logic [2**OPW-1:0] ILLEGAL_MASK = '0,
  parameter int                CNTW         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  ins_decode_stage_if.slave    bus,
  output logic [CNTW-1:0]      dec_count
);

  generate
    if (DATAW < IMMW) begin : g_bad_dataw
      $error("ins_decode_stage: DATAW must be >= IMMW");
    end
  endgenerate

  // Bundle layout {illegal, opcode, rt_rd, rs, imm_ext}
  localparam int BW = 1 + OPW + 2 * REGW + DATAW;

  logic [OPW-1:0]   dec_op;
  logic [REGW-1:0]  dec_rt;
  logic [REGW-1:0]  dec_rs;
  logic [DATAW-1:0] dec_imm;
  logic             dec_ill;
  logic [BW-1:0]    dec_bundle;

  ins_field_split #(
    .OPW          (OPW),
    .REGW         (REGW),
    .IMMW         (IMMW),
    .DATAW        (DATAW),
    .SEXT         (SEXT),
    .ILLEGAL_MASK (ILLEGAL_MASK)
  ) u_split (
    .instruct_i (bus.instruct),
    .opcode_o   (dec_op),
    .rt_rd_o    (dec_rt),
    .rs_o       (dec_rs),
    .imm_ext_o  (dec_imm),
    .illegal_o  (dec_ill)
  );

  assign dec_bundle = {dec_ill, dec_op, dec_rt, dec_rs, dec_imm};

  occ_e            state_q, state_d;
  logic [BW-1:0]   main_q;
  logic [BW-1:0]   skid_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            accept, handoff;
  logic            load_main, load_skid, promote;

  assign bus.in_ready  = (state_q != OCC_TWO);
  assign bus.out_valid = (state_q != OCC_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign handoff       = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d   = OCC_ONE;
            load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && !handoff) begin
            state_d   = OCC_TWO;
            load_skid = 1'b1;
          end else if (handoff && !accept) begin
            state_d   = OCC_EMPTY;
          end else if (accept && handoff) begin
            load_main = 1'b1;
          end
        end
        OCC_TWO: begin
          if (handoff) begin
            state_d = OCC_ONE;
            promote = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    // A handoff during a flush cycle is still a real delivery and counts
    if (handoff && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_main) begin
        main_q <= dec_bundle;
      end else if (promote) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_bundle;
      end
    end
  end

  assign {bus.illegal, bus.opcode, bus.rt_rd, bus.rs, bus.imm_ext} = main_q;
  assign dec_count = cnt_q;

endmodule

// File: tb/tb_ins_decode_stage.sv
// Directed bench: two stage instances (sign-extend/no illegal/16-bit count and zero-extend/opcode 7 illegal/2-bit count) share stimulus.
module tb_ins_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] instruct;
  logic       out_ready;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ins_decode_stage_if #(.OPW(3), .REGW(1), .IMMW(3), .DATAW(8)) bus_a ();
  ins_decode_stage_if #(.OPW(3), .REGW(1), .IMMW(3), .DATAW(8)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.instruct  = instruct;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.instruct  = instruct;
  assign bus_b.out_ready = out_ready;

  ins_decode_stage #(
    .OPW(3), .REGW(1), .IMMW(3), .DATAW(8), .SEXT(1),
    .ILLEGAL_MASK(8'h00), .CNTW(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a), .dec_count(cnt_a)
  );

  ins_decode_stage #(
    .OPW(3), .REGW(1), .IMMW(3), .DATAW(8), .SEXT(0),
    .ILLEGAL_MASK(8'h80), .CNTW(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b), .dec_count(cnt_b)
  );

  typedef struct {
    logic [7:0] instr;
    logic [2:0] op;
    logic       rt;
    logic       rs;
    logic [7:0] imm_s;
    logic [7:0] imm_z;
    logic       ill_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instruct = '0; out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_cnt_a, input logic [1:0] exp_cnt_b);
    check({tag, "_vld_a"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, "_vld_b"}, 32'(bus_b.out_valid), 32'd0);
    check({tag, "_rdy_a"}, 32'(bus_a.in_ready), 32'd1);
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'(exp_cnt_a));
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'(exp_cnt_b));
  endtask

  // Expected per-cycle observations for the back-pressured 5-word stream
  logic       st_rdy [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       st_vld [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] st_op  [9] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    int  nxt;
    logic rdy_seen;

    vecs[0] = '{8'b101_1_0_110, 3'd5, 1'b1, 1'b0, 8'hFE, 8'h06, 1'b0};
    vecs[1] = '{8'b011_0_1_100, 3'd3, 1'b0, 1'b1, 8'hFC, 8'h04, 1'b0};
    vecs[2] = '{8'b111_1_1_011, 3'd7, 1'b1, 1'b1, 8'h03, 8'h03, 1'b1};
    vecs[3] = '{8'b110_0_0_111, 3'd6, 1'b0, 1'b0, 8'hFF, 8'h07, 1'b0};
    vecs[4] = '{8'b000_1_0_000, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'b111_0_0_100, 3'd7, 1'b0, 1'b0, 8'hFC, 8'h04, 1'b1};

    do_reset();
    check_idle("reset", 16'd0, 2'd0);
    check("reset_op", 32'(bus_a.opcode), 32'd0);
    check("reset_imm", 32'(bus_a.imm_ext), 32'd0);
    check("reset_ill_b", 32'(bus_b.illegal), 32'd0);

    // Back-to-back decode, one word per cycle
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instruct = vecs[i].instr; out_ready = 1'b1;
      step();
      check($sformatf("v%0d_vld", i),   32'(bus_a.out_valid), 32'd1);
      check($sformatf("v%0d_rdy", i),   32'(bus_a.in_ready),  32'd1);
      check($sformatf("v%0d_op", i),    32'(bus_a.opcode),    32'(vecs[i].op));
      check($sformatf("v%0d_rt", i),    32'(bus_a.rt_rd),     32'(vecs[i].rt));
      check($sformatf("v%0d_rs", i),    32'(bus_a.rs),        32'(vecs[i].rs));
      check($sformatf("v%0d_imm_s", i), 32'(bus_a.imm_ext),   32'(vecs[i].imm_s));
      check($sformatf("v%0d_imm_z", i), 32'(bus_b.imm_ext),   32'(vecs[i].imm_z));
      check($sformatf("v%0d_ill_a", i), 32'(bus_a.illegal),   32'd0);
      check($sformatf("v%0d_ill_b", i), 32'(bus_b.illegal),   32'(vecs[i].ill_b));
      check($sformatf("v%0d_op_b", i),  32'(bus_b.opcode),    32'(vecs[i].op));
    end
    in_valid = 1'b0;
    step();
    check_idle("vec_end", 16'd6, 2'd3);

    // Stream of 5 words with consumer stalled for three cycles
    do_reset();
    nxt = 1;
    for (int c = 0; c < 9; c++) begin
      in_valid  = (nxt <= 5);
      instruct  = {3'(nxt), 5'b0};
      out_ready = !(c >= 2 && c <= 4);
      rdy_seen  = bus_a.in_ready;
      step();
      if (in_valid && rdy_seen) nxt++;
      check($sformatf("st%0d_rdy_a", c), 32'(bus_a.in_ready),  32'(st_rdy[c]));
      check($sformatf("st%0d_rdy_b", c), 32'(bus_b.in_ready),  32'(st_rdy[c]));
      check($sformatf("st%0d_vld", c),   32'(bus_a.out_valid), 32'(st_vld[c]));
      if (st_vld[c]) begin
        check($sformatf("st%0d_op", c),  32'(bus_a.opcode),    32'(st_op[c]));
      end
    end
    check("st_accepted", 32'(nxt), 32'd6);
    check_idle("st_end", 16'd5, 2'd3);

    // Flush while full: buffered and presented words are dropped
    in_valid = 1'b1; instruct = {3'd1, 5'b0}; out_ready = 1'b0;
    step();
    instruct = {3'd2, 5'b0};
    step();
    check("fl_full_rdy", 32'(bus_a.in_ready), 32'd0);
    flush = 1'b1; instruct = {3'd3, 5'b0};
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_idle("fl_full", 16'd5, 2'd3);
    step();
    step();
    check("fl_full_after", 32'(bus_a.out_valid), 32'd0);

    // Flush with a concurrent handoff and a presented word
    in_valid = 1'b1; instruct = {3'd4, 5'b0}; out_ready = 1'b1;
    step();
    check("fl_one_op", 32'(bus_a.opcode), 32'd4);
    flush = 1'b1; instruct = {3'd5, 5'b0};
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("fl_one", 16'd6, 2'd3);
    step();
    check("fl_one_after", 32'(bus_a.out_valid), 32'd0);

    // Reset while two words are buffered
    in_valid = 1'b1; instruct = {3'd1, 5'b0}; out_ready = 1'b0;
    step();
    instruct = {3'd2, 5'b0};
    step();
    check("rs_full_rdy", 32'(bus_a.in_ready), 32'd0);
    rst_n = 1'b0; instruct = {3'd6, 5'b1}; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check_idle("rs_mid", 16'd0, 2'd0);
    check("rs_mid_op", 32'(bus_a.opcode), 32'd0);
    step();
    step();
    check("rs_after_vld", 32'(bus_a.out_valid), 32'd0);
    check("rs_after_cnt", 32'(cnt_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
